pipeline_idex: RTL
==================

# pipeline_idex

ID/EX pipeline register with integrated load-use hazard detection and bubble/flush control. It captures decoded instruction state from the decode stage every cycle and presents it, registered, to the execution stage. It inserts a bubble on a load-use hazard or an EX-resolved redirect, and drives the stall that freezes PC and IF/ID. A saturating counter records inserted load-use bubbles for performance inspection.

## Interface
Parameters:
- CNTW, 32, width of load-use bubble counter

Ports (ID-side `id_*` input / EX-side `ex_*` output pairs share meaning):
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- hold  input  1  global freeze (e.g. memory wait); register keeps contents
- redirect  input  1  EX resolved taken branch/jump/jr this cycle; squash ID instruction
- id_valid / ex_valid  in/out  1  slot holds a real instruction
- id_instr / ex_instr  in/out  32  raw instruction word
- id_pcplus4 / ex_pcplus4  in/out  32  PC+4 of instruction
- id_regdataa / ex_regdataa, id_regdatab / ex_regdatab  in/out  32  register-file read data for rs, rt
- id_rs, id_rt, id_rd / ex_rs, ex_rt, ex_rd  in/out  5  register specifiers
- id_usesrt  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
- id_funct / ex_funct  in/out  6  function field
- id_aluop / ex_aluop  in/out  2  ALU decode class
- id_shiftl16, id_jumptoreg, id_jump, id_alusrc, id_nez, id_branch, id_regdst, id_regwrite, id_memwrite, id_memtoreg / matching ex_*  in/out  1 each  control bits
- stall  output  1  freeze PC and IF/ID this cycle
- bubbles  output  CNTW  saturating count of load-use bubbles inserted

## Operation
- Control bits = shiftl16, jumptoreg, jump, alusrc, nez, branch, regdst, regwrite, memwrite, memtoreg, valid. Bubble = all control bits 0, ex_instr = 32'h0 (nop), ex_funct/aluop = 0; datapath fields (pcplus4, regdata, rs/rt/rd) may load ID values but must not affect architectural state.
- hazard (combinational) = ex_valid & ex_memtoreg & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_usesrt & ex_rt == id_rt)).
- Per-edge update priority:
  1. hold = 1: all registers keep value; counter unchanged.
  2. redirect = 1: load bubble (ID instruction is wrong-path).
  3. hazard = 1: load bubble; bubbles += 1, saturating at all-ones.
  4. else: load all id_* into ex_*.
- stall = hold | (hazard & ~redirect). On redirect the IF/ID flush owns the frontend; stall must not also assert from hazard.
- A hazard stall lasts exactly one cycle: the bubble clears ex_valid, so hazard deasserts next cycle and the held ID instruction advances.
- $zero rule: ex_rt == 0 never causes a hazard.

## Timing
- Latency 1 cycle: id_* sampled at edge N appear on ex_* after edge N.
- stall, hazard: combinational, same cycle as the triggering ID/EX contents; no registered delay.
- Reset (async assert, any time incl. mid-stall): all ex_* = 0, ex_valid = 0, ex_instr = 0, bubbles = 0, hence stall = hold. Release takes effect at next clk edge with normal load.
- hold and redirect together: hold wins; redirect must be re-presented by EX (it is frozen too).
- hazard and redirect together: bubble loaded, bubbles not incremented, stall = 0.
- Counter at all-ones: remains all-ones on further hazards.

## Test plan
- Plain flow: id_instr=32'h012A4020 (add), id_regdataa=5, id_regdatab=7, id_regwrite=1 -> next cycle ex_instr=32'h012A4020, ex_regdataa=5, ex_regwrite=1, stall=0.
- Load-use: EX holds lw $8 (ex_memtoreg=1, ex_rt=8); ID add reads rs=8 -> stall=1, next cycle ex_valid=0, bubbles=1; following cycle add loaded, stall=0.
- No false hazard: EX lw with ex_rt=0, or ID rt=8 with id_usesrt=0 (addi) -> stall=0, bubbles=0.
- Redirect vs hazard: load-use condition and redirect=1 same cycle -> stall=0, ex_valid=0 next cycle, bubbles unchanged.
- Hold: hold=1 for 3 cycles with changing id_* -> ex_* unchanged, stall=1 throughout; hold release loads current id_*.
- Async reset mid-stall: assert reset between edges while stall=1 -> ex_valid=0, bubbles=0, stall=0 immediately; counter saturation check with CNTW=2: 4 hazards -> bubbles=3.

Source files
------------

// File: rtl/pipeline_idex.sv
// rtl/pipeline_idex.sv - ID/EX pipeline register with load-use hazard detection and bubble control
//
// Captures decoded instruction state from ID each cycle and presents it,
// registered, to EX. A load in EX whose destination is a source of the
// instruction in ID produces a one-cycle stall and a bubble in EX. A redirect
// resolved in EX squashes the ID instruction instead. Load-use bubbles are
// counted in a saturating counter.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   hold                  global freeze, every register keeps its value
//   redirect              EX resolved a taken branch/jump; ID is wrong-path
//   id_* / ex_*           decoded instruction state, ID input / EX output
//   id_usesrt             ID instruction reads rt as a source
//   stall                 freeze PC and IF/ID this cycle
//   bubbles               saturating count of inserted load-use bubbles

module pipeline_idex #(
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            redirect,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     id_pcplus4,
  input  logic [31:0]     id_regdataa,
  input  logic [31:0]     id_regdatab,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic            id_usesrt,
  input  logic [5:0]      id_funct,
  input  logic [1:0]      id_aluop,
  input  logic            id_shiftl16,
  input  logic            id_jumptoreg,
  input  logic            id_jump,
  input  logic            id_alusrc,
  input  logic            id_nez,
  input  logic            id_branch,
  input  logic            id_regdst,
  input  logic            id_regwrite,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  output logic            ex_valid,
  output logic [31:0]     ex_instr,
  output logic [31:0]     ex_pcplus4,
  output logic [31:0]     ex_regdataa,
  output logic [31:0]     ex_regdatab,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [5:0]      ex_funct,
  output logic [1:0]      ex_aluop,
  output logic            ex_shiftl16,
  output logic            ex_jumptoreg,
  output logic            ex_jump,
  output logic            ex_alusrc,
  output logic            ex_nez,
  output logic            ex_branch,
  output logic            ex_regdst,
  output logic            ex_regwrite,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            stall,
  output logic [CNTW-1:0] bubbles
);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic [31:0] regdataa;
    logic [31:0] regdatab;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        shiftl16;
    logic        jumptoreg;
    logic        jump;
    logic        alusrc;
    logic        nez;
    logic        branch;
    logic        regdst;
    logic        regwrite;
    logic        memwrite;
    logic        memtoreg;
  } idex_t;

  idex_t           stage_q, stage_d, id_s, bubble_s;
  logic [CNTW-1:0] bub_q, bub_d;
  logic            hazard;

  always_comb begin
    id_s = '{valid: id_valid, instr: id_instr, pcplus4: id_pcplus4,
             regdataa: id_regdataa, regdatab: id_regdatab,
             rs: id_rs, rt: id_rt, rd: id_rd, funct: id_funct, aluop: id_aluop,
             shiftl16: id_shiftl16, jumptoreg: id_jumptoreg, jump: id_jump,
             alusrc: id_alusrc, nez: id_nez, branch: id_branch, regdst: id_regdst,
             regwrite: id_regwrite, memwrite: id_memwrite, memtoreg: id_memtoreg};

    // Bubble keeps the ID datapath fields; with every control bit cleared
    // they cannot reach architectural state.
    bubble_s           = id_s;
    bubble_s.valid     = 1'b0;
    bubble_s.instr     = 32'h0;
    bubble_s.funct     = 6'h0;
    bubble_s.aluop     = 2'h0;
    bubble_s.shiftl16  = 1'b0;
    bubble_s.jumptoreg = 1'b0;
    bubble_s.jump      = 1'b0;
    bubble_s.alusrc    = 1'b0;
    bubble_s.nez       = 1'b0;
    bubble_s.branch    = 1'b0;
    bubble_s.regdst    = 1'b0;
    bubble_s.regwrite  = 1'b0;
    bubble_s.memwrite  = 1'b0;
    bubble_s.memtoreg  = 1'b0;
  end

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign hazard = stage_q.valid & stage_q.memtoreg & (stage_q.rt != 5'd0) & id_valid &
                  ((stage_q.rt == id_rs) | (id_usesrt & (stage_q.rt == id_rt)));

  // On redirect the IF/ID flush owns the frontend, so the hazard must not stall.
  assign stall = hold | (hazard & ~redirect);

  always_comb begin
    stage_d = id_s;
    bub_d   = bub_q;
    if (redirect) begin
      stage_d = bubble_s;
    end else if (hazard) begin
      stage_d = bubble_s;
      if (~&bub_q) bub_d = bub_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      bub_q   <= '0;
    end else if (!hold) begin
      stage_q <= stage_d;
      bub_q   <= bub_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_instr     = stage_q.instr;
  assign ex_pcplus4   = stage_q.pcplus4;
  assign ex_regdataa  = stage_q.regdataa;
  assign ex_regdatab  = stage_q.regdatab;
  assign ex_rs        = stage_q.rs;
  assign ex_rt        = stage_q.rt;
  assign ex_rd        = stage_q.rd;
  assign ex_funct     = stage_q.funct;
  assign ex_aluop     = stage_q.aluop;
  assign ex_shiftl16  = stage_q.shiftl16;
  assign ex_jumptoreg = stage_q.jumptoreg;
  assign ex_jump      = stage_q.jump;
  assign ex_alusrc    = stage_q.alusrc;
  assign ex_nez       = stage_q.nez;
  assign ex_branch    = stage_q.branch;
  assign ex_regdst    = stage_q.regdst;
  assign ex_regwrite  = stage_q.regwrite;
  assign ex_memwrite  = stage_q.memwrite;
  assign ex_memtoreg  = stage_q.memtoreg;
  assign bubbles      = bub_q;

endmodule
